image_stream_ctrl: RTL and testbench

- Host-side driver and collector for the 3x3 image filter's pixel interface.
- Streams a stored frame from a source memory into the filter (pixel + enable), then raises the process enable.
- Waits for the filter's finish flag, then captures the filter's raster output stream into a destination memory.
- Sits between the frame buffers and the filter core, one per filter instance.

---
 rtl/image_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_image_stream_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_ctrl.sv
// Host-side frame streamer/collector for the 3x3 image filter: feeds a stored frame in,
// waits for the filter to finish, then captures its raster output into destination memory.
module image_stream_ctrl #(
    parameter int IMG_W   = 410,
    parameter int IMG_H   = 361,
    parameter int ADDR_W  = 18,
    parameter int OUT_LAT = 1,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic [7:0]        pix_out,
    output logic              pix_en,
    output logic              proc_en,
    input  logic              filt_finish,
    input  logic [7:0]        filt_pix,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_data
);

    localparam int N    = IMG_W * IMG_H;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] SKIP_LAST = ADDR_W'((OUT_LAT >= 2) ? OUT_LAT - 2 : 0);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, FETCH, PROC, SKIP, CAPTURE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              cnt_end, cnt_end_nx;
    logic [TO_W-1:0]   to_cnt, to_nx;
    logic              finish_q;
    logic              cap_smp;

    // cnt is shared: read index in FETCH, latency count in SKIP, write index in CAPTURE
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cnt_end_nx = cnt_end;
        to_nx      = to_cnt;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = FETCH;
                    cnt_nx     = '0;
                    cnt_end_nx = 1'b0;
                end
            end
            FETCH: begin
                if (!cnt_end) begin
                    if (cnt == LAST) cnt_end_nx = 1'b1;
                    else             cnt_nx     = cnt + 1'b1;
                end else begin
                    // last pixel is on the filter input this cycle
                    state_nx = PROC;
                    to_nx    = '0;
                end
            end
            PROC: begin
                if (to_cnt == '0 && filt_finish) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end else if (filt_finish && !finish_q) begin
                    cnt_nx     = '0;
                    cnt_end_nx = 1'b0;
                    state_nx   = (OUT_LAT <= 1) ? CAPTURE : SKIP;
                end else if (to_cnt == TO_MAX) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    to_nx = to_cnt + 1'b1;
                end
            end
            SKIP: begin
                if (cnt == SKIP_LAST) begin
                    cnt_nx   = '0;
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                if (cnt_end) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    cnt_end_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign src_rd_en = (state == FETCH) && !cnt_end;
    assign src_addr  = src_rd_en ? cnt : '0;
    assign pix_out   = pix_en ? src_data : 8'd0;
    assign proc_en   = (state == PROC) || (state == SKIP) || (state == CAPTURE);
    assign cap_smp   = (state == CAPTURE) && !cnt_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cnt_end  <= 1'b0;
            to_cnt   <= '0;
            finish_q <= 1'b0;
            pix_en   <= 1'b0;
            dst_we   <= 1'b0;
            dst_addr <= '0;
            dst_data <= 8'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cnt_end  <= cnt_end_nx;
            to_cnt   <= to_nx;
            finish_q <= filt_finish;
            pix_en   <= src_rd_en;
            dst_we   <= cap_smp;
            if (cap_smp) begin
                dst_addr <= cnt;
                dst_data <= filt_pix;
            end
        end
    end

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Randomized bench for image_stream_ctrl: two instances (OUT_LAT 1 and 3) share stimulus and
// are compared each cycle against a schedule model derived from the frame timing rules.
module tb_image_stream_ctrl;

    localparam int W = 4, H = 3, N = W * H, AW = 4, TMO = 50;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, filt_finish = 1'b0;
    logic [7:0] filt_pix = 8'd0;
    always #5 clk = ~clk;

    logic busy0, done0, err0, rd0, pe0, pr0, we0;
    logic busy1, done1, err1, rd1, pe1, pr1, we1;
    logic [AW-1:0] sa0, da0, sa1, da1;
    logic [7:0] sd0, po0, dd0, sd1, po1, dd1;

    image_stream_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_LAT(1), .TIMEOUT(TMO)) u0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0), .err(err0),
        .src_rd_en(rd0), .src_addr(sa0), .src_data(sd0), .pix_out(po0), .pix_en(pe0),
        .proc_en(pr0), .filt_finish(filt_finish), .filt_pix(filt_pix),
        .dst_we(we0), .dst_addr(da0), .dst_data(dd0));

    image_stream_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_LAT(3), .TIMEOUT(TMO)) u1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1), .err(err1),
        .src_rd_en(rd1), .src_addr(sa1), .src_data(sd1), .pix_out(po1), .pix_en(pe1),
        .proc_en(pr1), .filt_finish(filt_finish), .filt_pix(filt_pix),
        .dst_we(we1), .dst_addr(da1), .dst_data(dd1));

    logic [7:0] mem [16];
    logic [7:0] pv [256];
    logic [7:0] dmem0 [16];
    logic [7:0] dmem1 [16];
    logic [7:0] pixrec [1024];
    int wc0 = 0, wc1 = 0, pc0 = 0;
    int cf = 0, cur_t = 0;
    bit active = 0;
    int n_cmp = 0, n_bad = 0;

    // memories on the bench side
    always @(posedge clk) begin
        if (rd0) sd0 <= mem[sa0];
        if (rd1) sd1 <= mem[sa1];
        if (we0) begin dmem0[da0] <= dd0; wc0 <= wc0 + 1; end
        if (we1) begin dmem1[da1] <= dd1; wc1 <= wc1 + 1; end
        if (pe0) begin pixrec[pc0 % 1024] <= po0; pc0 <= pc0 + 1; end
    end

    typedef struct {
        bit busy, done, err, rd, pe, pr, we;
        int sa, po, da, dd;
    } exp_t;

    // t = cycles since the edge that accepted start; PROC begins at t = N+2
    function automatic exp_t model(int t, int lat);
        exp_t e;
        int p0, tw0, tend;
        bit cap;
        e.busy = 0; e.done = 0; e.err = 0; e.rd = 0; e.pe = 0; e.pr = 0; e.we = 0;
        e.sa = 0; e.po = 0; e.da = 0; e.dd = 0;
        p0   = N + 2;
        cap  = (cf > 0) && (cf < TMO);
        tw0  = p0 + cf + lat + 1;
        tend = (cf == 0) ? p0 : (cap ? tw0 + N - 1 : p0 + TMO);
        if (t < 1 || t > tend) return e;
        e.busy = 1;
        if (t <= N) begin e.rd = 1; e.sa = t - 1; end
        if (t >= 2 && t <= N + 1) begin e.pe = 1; e.po = int'(mem[t - 2]); end
        if (t >= p0) e.pr = 1;
        if (t == tend) begin e.done = cap; e.err = !cap; end
        if (cap && t >= tw0) begin
            e.we = 1; e.da = t - tw0; e.dd = int'(pv[cf + lat + (t - tw0)]);
        end
        return e;
    endfunction

    task automatic chk(string nm, int inst, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s u%0d t=%0d got %0d expected %0d", nm, inst, cur_t, act, expv);
        end
    endtask

    task automatic cmp_inst(int i, int lat, logic b, logic d, logic e, logic rd, logic [AW-1:0] sa,
                            logic pe, logic [7:0] po, logic pr, logic we, logic [AW-1:0] da,
                            logic [7:0] dd);
        exp_t x;
        x = model(cur_t, lat);
        chk("busy", i, int'(b), int'(x.busy));
        chk("done", i, int'(d), int'(x.done));
        chk("err", i, int'(e), int'(x.err));
        chk("src_rd_en", i, int'(rd), int'(x.rd));
        chk("pix_en", i, int'(pe), int'(x.pe));
        chk("proc_en", i, int'(pr), int'(x.pr));
        chk("dst_we", i, int'(we), int'(x.we));
        if (x.rd) chk("src_addr", i, int'(sa), x.sa);
        if (x.pe) chk("pix_out", i, int'(po), x.po);
        if (x.we) begin
            chk("dst_addr", i, int'(da), x.da);
            chk("dst_data", i, int'(dd), x.dd);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            cmp_inst(0, 1, busy0, done0, err0, rd0, sa0, pe0, po0, pr0, we0, da0, dd0);
            cmp_inst(1, 3, busy1, done1, err1, rd1, sa1, pe1, po1, pr1, we1, da1, dd1);
        end
    end

    task automatic all_zero(string tag);
        chk({tag, "_busy"}, 0, int'(busy0 | busy1), 0);
        chk({tag, "_done"}, 0, int'(done0 | done1), 0);
        chk({tag, "_err"}, 0, int'(err0 | err1), 0);
        chk({tag, "_rd"}, 0, int'(rd0 | rd1), 0);
        chk({tag, "_saddr"}, 0, int'(sa0 | sa1), 0);
        chk({tag, "_pix"}, 0, int'(po0 | po1), 0);
        chk({tag, "_pix_en"}, 0, int'(pe0 | pe1), 0);
        chk({tag, "_proc_en"}, 0, int'(pr0 | pr1), 0);
        chk({tag, "_we"}, 0, int'(we0 | we1), 0);
        chk({tag, "_daddr"}, 0, int'(da0 | da1), 0);
        chk({tag, "_ddata"}, 0, int'(dd0 | dd1), 0);
    endtask

    task automatic run_frame(int cf_i);
        int tmax;
        cf   = cf_i;
        tmax = N + 2 + ((cf == 0) ? 0 : ((cf < TMO) ? cf + 3 + N : TMO)) + 2;
        @(posedge clk); #1;
        start = 1'b1; cur_t = 0; active = 1; filt_finish = 1'b0; filt_pix = 8'd0;
        for (int t = 1; t <= tmax; t++) begin
            @(posedge clk); #1;
            cur_t       = t;
            start       = (t >= 2 && t <= N) ? 1'($urandom_range(0, 1)) : 1'b0;
            filt_finish = (t >= N + 2 + cf);
            filt_pix    = (t >= N + 2) ? pv[t - (N + 2)] : 8'd0;
        end
        @(posedge clk); #1;
        active = 0; start = 1'b0; filt_finish = 1'b0; filt_pix = 8'd0;
    endtask

    // frame mem[i]=i+16, filter presents 100+k starting one cycle after finish at PROC cycle 20
    task automatic directed_frame();
        int w0, w1, p;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
        for (int c = 0; c < 256; c++) pv[c] = (c >= 21) ? 8'(100 + c - 21) : 8'(200 + c);
        w0 = wc0; w1 = wc1; p = pc0;
        run_frame(20);
        chk("lit_pix_count", 0, pc0 - p, 12);
        chk("lit_pix_first", 0, int'(pixrec[p % 1024]), 16);
        chk("lit_pix_last", 0, int'(pixrec[(p + 11) % 1024]), 27);
        chk("lit_wr_count", 0, wc0 - w0, 12);
        chk("lit_wr_count", 1, wc1 - w1, 12);
        chk("lit_dst0", 0, int'(dmem0[0]), 100);
        chk("lit_dst11", 0, int'(dmem0[11]), 111);
        chk("lit_dst0", 1, int'(dmem1[0]), 102);
        chk("lit_dst11", 1, int'(dmem1[11]), 113);
    endtask

    initial begin
        int w0, w1;
        for (int i = 0; i < 256; i++) pv[i] = 8'd0;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'd0; dmem0[i] = 8'd0; dmem1[i] = 8'd0; end
        #3 all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;

        directed_frame();

        // timeout: finish never rises
        w0 = wc0; w1 = wc1;
        run_frame(1000);
        chk("timeout_no_we", 0, wc0 - w0, 0);
        chk("timeout_no_we", 1, wc1 - w1, 0);

        // stale finish already high on PROC entry
        w0 = wc0; w1 = wc1;
        run_frame(0);
        chk("stale_no_we", 0, wc0 - w0, 0);
        chk("stale_no_we", 1, wc1 - w1, 0);

        // reset mid-FETCH after 5 pixels
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
        cf = 20;
        @(posedge clk); #1;
        start = 1'b1; cur_t = 0; active = 1;
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk); #1;
            start = 1'b0; cur_t = t;
        end
        @(negedge clk); #1;
        active = 0; reset = 1'b1;
        #1 all_zero("midreset");
        w0 = wc0;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        chk("midreset_no_we", 0, wc0 - w0, 0);
        directed_frame();

        for (int r = 0; r < 10; r++) begin
            int c;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 256; i++) pv[i] = 8'($urandom);
            case (r % 4)
                0:       c = 0;
                1:       c = 1000;
                default: c = $urandom_range(1, 45);
            endcase
            run_frame(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
